// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: border, colour bars, bouncing box and scrolling checkerboard.
// Pattern select and animation state change only on the frame tick; the pixel output is registered.
module vga_pattern_gen #(
  parameter int COLOR_BITS  = 1,
  parameter int H_ACT_START = 160,
  parameter int V_ACT_START = 41,
  parameter int ACT_W       = 640,
  parameter int ACT_H       = 480,
  parameter int BORDER      = 10,
  parameter int BAR_W       = 80,
  parameter int BOX_SIZE    = 32,
  parameter int BOX_STEP    = 2,
  parameter int CHECK_LOG2  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                h_count,
  input  logic [9:0]                v_count,
  input  logic                      bright,
  input  logic [1:0]                mode,
  output logic [3*COLOR_BITS-1:0]   rgb,
  output logic                      frame_start
);

  localparam int RGB_W = 3 * COLOR_BITS;
  localparam int BC_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [9:0] H_FIRST  = 10'(H_ACT_START);
  localparam logic [9:0] H_LAST   = 10'(H_ACT_START + ACT_W - 1);
  localparam logic [9:0] V_FIRST  = 10'(V_ACT_START);
  localparam logic [9:0] V_LAST   = 10'(V_ACT_START + ACT_H - 1);
  localparam logic [9:0] X_MAX    = 10'(ACT_W - BOX_SIZE);
  localparam logic [9:0] Y_MAX    = 10'(ACT_H - BOX_SIZE);
  localparam logic [9:0] STEP     = 10'(BOX_STEP);
  localparam logic [9:0] BOX_LAST = 10'(BOX_SIZE - 1);
  localparam logic [9:0] BRD      = 10'(BORDER);
  localparam logic [9:0] BRD_H    = 10'(ACT_W - BORDER);
  localparam logic [9:0] BRD_V    = 10'(ACT_H - BORDER);
  localparam logic [BC_W-1:0] BAR_LAST = BC_W'(BAR_W - 1);

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;

  function automatic logic [RGB_W-1:0] expand(input logic [2:0] c);
    return {{COLOR_BITS{c[2]}}, {COLOR_BITS{c[1]}}, {COLOR_BITS{c[0]}}};
  endfunction

  // Returns {dir, pos} after one frame of motion; clamps at either wall and reverses.
  function automatic logic [10:0] next_axis(input logic [9:0] pos, input logic dir,
                                            input logic [9:0] mx);
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, STEP};
    if (dir && (sum >= {1'b0, mx}))
      return {1'b0, mx};
    else if (!dir && (pos <= STEP))
      return {1'b1, 10'd0};
    else if (dir)
      return {1'b1, pos + STEP};
    else
      return {1'b0, pos - STEP};
  endfunction

  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             fs_q;
  logic [1:0]       mode_q, mode_d;
  logic [9:0]       box_x_q, box_x_d, box_y_q, box_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [9:0]       scroll_q, scroll_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [BC_W-1:0]  bar_cnt_q, bar_cnt_d;

  logic             tick, bar_start, in_act, in_box, on_border;
  logic [BC_W-1:0]  cnt_eff;
  logic [2:0]       idx_eff, pix;
  logic [9:0]       hr, vr, chk;
  logic [10:0]      axis_x, axis_y;

  assign tick = (h_count == 10'd0) && (v_count == 10'd0);
  assign hr   = h_count - H_FIRST;
  assign vr   = v_count - V_FIRST;

  always_comb begin
    // Bar counter restarts on the first active pixel, so that pixel already belongs to bar 0.
    bar_start = (h_count == H_FIRST);
    cnt_eff   = bar_start ? '0 : bar_cnt_q;
    idx_eff   = bar_start ? 3'd0 : bar_idx_q;
    bar_cnt_d = cnt_eff + BC_W'(1);
    bar_idx_d = idx_eff;
    if (cnt_eff == BAR_LAST) begin
      bar_cnt_d = '0;
      if (idx_eff != 3'd7) bar_idx_d = idx_eff + 3'd1;
    end

    axis_x   = next_axis(box_x_q, dir_x_q, X_MAX);
    axis_y   = next_axis(box_y_q, dir_y_q, Y_MAX);
    mode_d   = mode_q;
    box_x_d  = box_x_q;
    dir_x_d  = dir_x_q;
    box_y_d  = box_y_q;
    dir_y_d  = dir_y_q;
    scroll_d = scroll_q;
    if (tick) begin
      mode_d             = mode;
      {dir_x_d, box_x_d} = axis_x;
      {dir_y_d, box_y_d} = axis_y;
      scroll_d           = scroll_q + 10'd1;
    end

    in_act    = (h_count >= H_FIRST) && (h_count <= H_LAST) &&
                (v_count >= V_FIRST) && (v_count <= V_LAST);
    in_box    = (hr >= box_x_q) && (hr <= box_x_q + BOX_LAST) &&
                (vr >= box_y_q) && (vr <= box_y_q + BOX_LAST);
    on_border = (hr < BRD) || (hr >= BRD_H) || (vr < BRD) || (vr >= BRD_V);
    chk       = (hr + scroll_q) ^ vr;

    pix = BLACK;
    case (mode_q)
      2'd0:    pix = on_border ? RED : WHITE;
      2'd1:    pix = WHITE ^ idx_eff;
      2'd2:    pix = in_box ? GREEN : BLACK;
      default: pix = chk[CHECK_LOG2] ? WHITE : BLACK;
    endcase
    if (!bright || !in_act) pix = BLACK;
    rgb_d = expand(pix);
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q     <= '0;
      fs_q      <= 1'b0;
      mode_q    <= 2'd0;
      box_x_q   <= 10'd0;
      box_y_q   <= 10'd0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      scroll_q  <= 10'd0;
      bar_idx_q <= 3'd0;
      bar_cnt_q <= '0;
    end else begin
      rgb_q     <= rgb_d;
      fs_q      <= tick;
      mode_q    <= mode_d;
      box_x_q   <= box_x_d;
      box_y_q   <= box_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      scroll_q  <= scroll_d;
      bar_idx_q <= bar_idx_d;
      bar_cnt_q <= bar_cnt_d;
    end
  end

  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen with a behavioural pixel model and an expected-value queue.
module tb_vga_pattern_gen;

  localparam int HS = 160, VS = 41, AW = 640, AH = 480;
  localparam int BW = 80, BS = 32, STP = 2, BRD = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_count, v_count;
  logic        bright;
  logic [1:0]  mode;
  logic [2:0]  rgb1;
  logic        fs1;
  logic [11:0] rgb4;
  logic        fs4;

  always #5 clk = ~clk;

  vga_pattern_gen #(.COLOR_BITS(1)) u_dut (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .bright(bright), .mode(mode), .rgb(rgb1), .frame_start(fs1)
  );

  vga_pattern_gen #(.COLOR_BITS(4)) u_dut4 (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .bright(bright), .mode(mode), .rgb(rgb4), .frame_start(fs4)
  );

  typedef struct {
    logic [2:0] rgb;
    logic       fs;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mode_m, bx, by, dx, dy, scroll_m;

  function automatic logic [2:0] mdl(input int h, input int v, input bit b);
    int hr, vr, idx;
    if (!b || h < HS || h > HS + AW - 1 || v < VS || v > VS + AH - 1) return 3'b000;
    hr = h - HS;
    vr = v - VS;
    case (mode_m)
      0: return (hr < BRD || hr >= AW - BRD || vr < BRD || vr >= AH - BRD) ? 3'b100 : 3'b111;
      1: begin
        idx = hr / BW;
        if (idx > 7) idx = 7;
        return 3'b111 ^ 3'(idx);
      end
      2: return (hr >= bx && hr < bx + BS && vr >= by && vr < by + BS) ? 3'b010 : 3'b000;
      default: return (((((hr + scroll_m) % 1024) ^ vr) & 32) != 0) ? 3'b111 : 3'b000;
    endcase
  endfunction

  function automatic logic [11:0] x4(input logic [2:0] c);
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

  task automatic adv(inout int p, inout int d, input int mx);
    if (d == 1 && p + STP >= mx) begin p = mx; d = 0; end
    else if (d == 0 && p <= STP) begin p = 0; d = 1; end
    else if (d == 1) p = p + STP;
    else p = p - STP;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int h, input int v, input bit b, input string tag);
    exp_t e;
    bit   tk;
    h_count = 10'(h);
    v_count = 10'(v);
    bright  = b;
    tk      = (h == 0 && v == 0);
    e.tag   = tag;
    if (reset) begin
      e.rgb = 3'b000;
      e.fs  = 1'b0;
    end else begin
      e.rgb = mdl(h, v, b);
      e.fs  = tk;
    end
    sb.push_back(e);
    if (reset) begin
      mode_m = 0; bx = 0; by = 0; dx = 1; dy = 1; scroll_m = 0;
    end else if (tk) begin
      mode_m = int'(mode);
      adv(bx, dx, AW - BS);
      adv(by, dy, AH - BS);
      scroll_m = (scroll_m + 1) % 1024;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "/rgb"}, 12'(rgb1), 12'(e.rgb));
    check({e.tag, "/rgb4"}, rgb4, x4(e.rgb));
    check({e.tag, "/fs"}, 12'(fs1), 12'(e.fs));
  endtask

  initial begin
    reset = 1'b1; mode = 2'd0; h_count = '0; v_count = '0; bright = 1'b0;
    mode_m = 0; bx = 0; by = 0; dx = 1; dy = 1; scroll_m = 0;

    for (int i = 0; i < 3; i++)
      step(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
           1'($urandom_range(0, 1)), "reset");
    reset = 1'b0;
    step(0, 0, 0, "tick0");
    step(10, 0, 0, "post_tick");

    step(165, 45, 1, "m0_red");
    step(400, 200, 1, "m0_white");
    step(100, 200, 1, "m0_hblank");
    step(400, 200, 0, "m0_dark");
    step(169, 200, 1, "m0_hr9");
    step(170, 200, 1, "m0_hr10");
    step(789, 200, 1, "m0_hr629");
    step(790, 200, 1, "m0_hr630");
    step(799, 200, 1, "m0_hlast");
    step(800, 200, 1, "m0_hpast");
    step(400, 40, 1, "m0_vpre");
    step(400, 520, 1, "m0_vlast");
    step(400, 521, 1, "m0_vpast");

    mode = 2'd1;
    step(0, 0, 0, "tick_m1");
    mode = 2'd0;
    for (int h = 150; h <= 805; h++) step(h, 100, 1, "m1_bar");

    mode = 2'd2;
    for (int f = 0; f < 320; f++) begin
      step(0, 0, 0, "tick_m2");
      step(HS + bx, VS + by, 1, "m2_corner");
      step(HS + bx + BS - 1, VS + by + BS - 1, 1, "m2_far");
      step(HS + bx + BS, VS + by, 1, "m2_right");
      step(HS + bx - 1, VS + by, 1, "m2_left");
    end

    step(300, 200, 1, "pre_rst");
    reset = 1'b1;
    step(300, 200, 1, "rst_mid");
    reset = 1'b0;
    mode = 2'd0;
    for (int h = 160; h <= 200; h++) step(h, 200, 1, "sw_m0");
    mode = 2'd3;
    for (int h = 160; h <= 260; h++) step(h, 200, 1, "sw_hold");
    step(0, 0, 0, "tick_m3");
    step(10, 0, 0, "post_tick_m3");
    for (int h = 160; h <= 260; h++) step(h, 200, 1, "m3_chk");
    for (int v = 41; v <= 110; v++) step(200, v, 1, "m3_col");

    mode = 2'd2;
    step(0, 0, 0, "tick_m2b");
    step(HS + 4, VS + 4, 1, "m2b_corner");
    step(HS + 3, VS + 4, 1, "m2b_left");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
